// File: rtl/mram_host_pkg.sv
// Shared definitions for the MRAM serial host: bridge strobe codes, FSM
// state encodings and default field widths.
package mram_host_pkg;

   localparam int unsigned DEF_ADDR_W     = 20;
   localparam int unsigned DEF_DATA_W     = 16;
   localparam int unsigned DEF_LEN_W      = 8;
   localparam int unsigned DEF_ACCESS_CYC = 4;
   localparam int unsigned DEF_CAP_LAT    = 1;

   // read_write_sel codes, also decoded by the bridge
   localparam logic [2:0] RWS_IDLE  = 3'b000;
   localparam logic [2:0] RWS_WRITE = 3'b001;
   localparam logic [2:0] RWS_READ  = 3'b010;

   typedef logic [3:0] host_state_t;

   localparam host_state_t ST_IDLE     = 4'd0;
   localparam host_state_t ST_SH_LEN   = 4'd1;
   localparam host_state_t ST_SH_ADDR  = 4'd2;
   localparam host_state_t ST_SH_DATA  = 4'd3;
   localparam host_state_t ST_STROBE   = 4'd4;
   localparam host_state_t ST_CAP_WAIT = 4'd5;
   localparam host_state_t ST_CAPTURE  = 4'd6;
   localparam host_state_t ST_NEXT     = 4'd7;
   localparam host_state_t ST_DONE     = 4'd8;

   // Strobe code for a latched operation (0 = write, 1 = read)
   function automatic logic [2:0] op_code(input logic op);
      return op ? RWS_READ : RWS_WRITE;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register; the MSB is presented first.
module piso_shift #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_shift,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sh;

   // Load has priority over shift; zeros fill in behind the word
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sh <= '0;
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= {r_sh[WIDTH-2:0], 1'b0};
      end
   end

   assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/mram_serial_host.sv
// Serial host engine for the MRAM bridge: serializes burst length, address
// and write data, sequences the access strobe and deserializes read words.
module mram_serial_host
   import mram_host_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned LEN_W      = DEF_LEN_W,
   parameter int unsigned ACCESS_CYC = DEF_ACCESS_CYC,
   parameter int unsigned CAP_LAT    = DEF_CAP_LAT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_op,
   input  logic              i_req_burst,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic [DATA_W-1:0] i_req_wdata,
   input  logic              i_wdata_valid,
   output logic              o_wdata_ready,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_rdata_valid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_burst_en,
   output logic              o_mode_sel,
   output logic              o_burst_len_ser,
   output logic              o_addr_ser,
   output logic              o_data_ser,
   output logic [2:0]        o_read_write_sel,
   input  logic              i_ser_data_in
);

   localparam int unsigned CNT_W = 16;

   localparam logic [CNT_W-1:0] LAST_LEN   = CNT_W'(LEN_W - 1);
   localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_ACC   = CNT_W'(ACCESS_CYC - 1);
   localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'((CAP_LAT > 0) ? CAP_LAT - 1 : 0);
   // Write data starts this many cycles into SH_ADDR so both fields end together
   localparam logic [CNT_W-1:0] DATA_START = CNT_W'(ADDR_W - DATA_W);

   host_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_op;
   logic              r_burst;
   logic [LEN_W-1:0]  r_beats;
   logic [DATA_W-1:0] r_cap;

   host_state_t       w_state_d;
   logic [CNT_W-1:0]  w_cnt_d;
   logic [LEN_W-1:0]  w_beats_d;
   logic              w_accept;
   logic              w_data_active;
   logic              w_data_load;
   logic [DATA_W-1:0] w_data_word;
   logic              w_len_msb;
   logic              w_addr_msb;
   logic              w_data_msb;

   assign w_accept      = (r_state == ST_IDLE) && i_req_valid;
   assign w_data_active = ((r_state == ST_SH_ADDR) && !r_op && (r_cnt >= DATA_START)) ||
                          (r_state == ST_SH_DATA);
   assign w_data_load   = w_accept ||
                          ((r_state == ST_NEXT) && !r_op && i_wdata_valid);
   assign w_data_word   = (r_state == ST_IDLE) ? i_req_wdata : i_wdata;

   piso_shift #(.WIDTH(LEN_W)) u_len_sh (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_accept),
      .i_data  (i_req_len),
      .i_shift (r_state == ST_SH_LEN),
      .o_msb   (w_len_msb)
   );

   piso_shift #(.WIDTH(ADDR_W)) u_addr_sh (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_accept),
      .i_data  (i_req_addr),
      .i_shift (r_state == ST_SH_ADDR),
      .o_msb   (w_addr_msb)
   );

   piso_shift #(.WIDTH(DATA_W)) u_data_sh (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_data_load),
      .i_data  (w_data_word),
      .i_shift (w_data_active),
      .o_msb   (w_data_msb)
   );

   // Next-state, per-state cycle counter and remaining-beat bookkeeping
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt + 1'b1;
      w_beats_d = r_beats;
      case (r_state)
         ST_IDLE: begin
            w_cnt_d = '0;
            if (w_accept) begin
               w_state_d = i_req_burst ? ST_SH_LEN : ST_SH_ADDR;
               w_beats_d = (!i_req_burst || (i_req_len == '0)) ? LEN_W'(1) : i_req_len;
            end
         end
         ST_SH_LEN: if (r_cnt == LAST_LEN) begin
            w_state_d = ST_SH_ADDR;
            w_cnt_d   = '0;
         end
         ST_SH_ADDR: if (r_cnt == LAST_ADDR) begin
            w_state_d = ST_STROBE;
            w_cnt_d   = '0;
         end
         ST_SH_DATA: if (r_cnt == LAST_DATA) begin
            w_state_d = ST_STROBE;
            w_cnt_d   = '0;
         end
         ST_STROBE: if (r_cnt == LAST_ACC) begin
            w_cnt_d = '0;
            if (r_op) begin
               w_state_d = (CAP_LAT == 0) ? ST_CAPTURE : ST_CAP_WAIT;
            end else begin
               // Writes only visit NEXT when another word is still to come
               w_state_d = (r_beats > LEN_W'(1)) ? ST_NEXT : ST_DONE;
            end
         end
         ST_CAP_WAIT: if (r_cnt == LAST_CAP) begin
            w_state_d = ST_CAPTURE;
            w_cnt_d   = '0;
         end
         ST_CAPTURE: if (r_cnt == LAST_DATA) begin
            w_state_d = ST_NEXT;
            w_cnt_d   = '0;
         end
         ST_NEXT: begin
            w_cnt_d = '0;
            if (r_op) begin
               w_beats_d = r_beats - LEN_W'(1);
               w_state_d = (r_beats > LEN_W'(1)) ? ST_STROBE : ST_DONE;
            end else if (i_wdata_valid) begin
               w_beats_d = r_beats - LEN_W'(1);
               w_state_d = ST_SH_DATA;
            end
         end
         ST_DONE: begin
            w_cnt_d   = '0;
            w_state_d = ST_IDLE;
         end
         default: begin
            w_cnt_d   = '0;
            w_state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any command in flight
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= 1'b0;
         r_burst <= 1'b0;
         r_beats <= '0;
         r_cap   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_beats <= w_beats_d;
         if (w_accept) begin
            r_op    <= i_req_op;
            r_burst <= i_req_burst;
         end
         if (r_state == ST_CAPTURE) begin
            r_cap <= {r_cap[DATA_W-2:0], i_ser_data_in};
         end
      end
   end

   // Output decode; serial lines are forced low outside their shift states
   always_comb begin
      o_req_ready      = (r_state == ST_IDLE) && i_rst;
      o_busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
      o_done           = (r_state == ST_DONE);
      o_rdata_valid    = (r_state == ST_NEXT) && r_op;
      o_rdata          = r_cap;
      o_wdata_ready    = (r_state == ST_NEXT) && !r_op;
      o_mode_sel       = r_burst;
      o_burst_en       = r_burst && ((r_state == ST_STROBE) || (r_state == ST_CAP_WAIT) ||
                                     (r_state == ST_CAPTURE) || (r_state == ST_NEXT));
      o_read_write_sel = (r_state == ST_STROBE) ? op_code(r_op) : RWS_IDLE;
      o_burst_len_ser  = (r_state == ST_SH_LEN) && w_len_msb;
      o_addr_ser       = (r_state == ST_SH_ADDR) && w_addr_msb;
      o_data_ser       = w_data_active && w_data_msb;
   end

endmodule

// File: tb/tb_mram_serial_host.sv
// Directed bench for mram_serial_host: per-cycle output log plus a simple
// PTS model that returns read words after each READ strobe.
module tb_mram_serial_host;
   import mram_host_pkg::*;

   localparam int CAP_LAT = 1;
   localparam int LOG_N   = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_op = 1'b0;
   logic        req_burst = 1'b0;
   logic [19:0] req_addr = '0;
   logic [7:0]  req_len = '0;
   logic [15:0] req_wdata = '0;
   logic        wdata_valid = 1'b0;
   logic [15:0] wdata = '0;
   logic        ser_in = 1'b0;

   logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_busy, o_done;
   logic        o_burst_en, o_mode_sel, o_len_ser, o_addr_ser, o_data_ser;
   logic [15:0] o_rdata;
   logic [2:0]  o_rws;

   typedef struct packed {
      logic        req_ready;
      logic        busy;
      logic        done;
      logic        rv;
      logic        burst_en;
      logic        mode_sel;
      logic        len_ser;
      logic        addr_ser;
      logic        data_ser;
      logic        wready;
      logic [2:0]  rws;
      logic [15:0] rdata;
   } snap_t;

   snap_t log_q [LOG_N];
   int    cyc = 0;
   int    n_vec = 0;
   int    n_err = 0;

   mram_serial_host u_dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .i_req_valid      (req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_op         (req_op),
      .i_req_burst      (req_burst),
      .i_req_addr       (req_addr),
      .i_req_len        (req_len),
      .i_req_wdata      (req_wdata),
      .i_wdata_valid    (wdata_valid),
      .o_wdata_ready    (o_wdata_ready),
      .i_wdata          (wdata),
      .o_rdata_valid    (o_rdata_valid),
      .o_rdata          (o_rdata),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_burst_en       (o_burst_en),
      .o_mode_sel       (o_mode_sel),
      .o_burst_len_ser  (o_len_ser),
      .o_addr_ser       (o_addr_ser),
      .o_data_ser       (o_data_ser),
      .o_read_write_sel (o_rws),
      .i_ser_data_in    (ser_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Snapshot every output mid-cycle, indexed by cycle number
   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         log_q[cyc] <= '{req_ready: o_req_ready, busy: o_busy, done: o_done,
                         rv: o_rdata_valid, burst_en: o_burst_en, mode_sel: o_mode_sel,
                         len_ser: o_len_ser, addr_ser: o_addr_ser, data_ser: o_data_ser,
                         wready: o_wdata_ready, rws: o_rws, rdata: o_rdata};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs_now();
      return 32'({o_req_ready, o_busy, o_done, o_rdata_valid, o_burst_en, o_mode_sel,
                  o_len_ser, o_addr_ser, o_data_ser, o_wdata_ready, o_rws, o_rdata});
   endfunction

   // Rebuild a serial field MSB first: fld 0 = len, 1 = addr, 2 = data
   function automatic logic [31:0] ser_word(input int start, input int n, input int fld);
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++) begin
         logic b;
         case (fld)
            0:       b = log_q[start+i].len_ser;
            1:       b = log_q[start+i].addr_ser;
            default: b = log_q[start+i].data_ser;
         endcase
         w = {w[30:0], b};
      end
      return w;
   endfunction

   function automatic logic [31:0] rws_seq(input int start, input int n);
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++) w = {w[28:0], log_q[start+i].rws};
      return w;
   endfunction

   // fld 0 = rdata_valid, 1 = done, 2 = wdata_ready
   function automatic int count_fld(input int a, input int b, input int fld);
      int n = 0;
      for (int i = a; i <= b; i++) begin
         case (fld)
            0:       n += int'(log_q[i].rv);
            1:       n += int'(log_q[i].done);
            default: n += int'(log_q[i].wready);
         endcase
      end
      return n;
   endfunction

   function automatic int count_strobes(input int a, input int b, input logic [2:0] code);
      int n = 0;
      for (int i = a; i <= b; i++) begin
         if (log_q[i].rws == code && log_q[i-1].rws != code) n++;
      end
      return n;
   endfunction

   // sel: 0 done, 1 READ strobe, 2 strobe no longer READ, 3 wdata_ready
   task automatic wait_for(input int sel, input int budget, input string tag, output int at);
      bit hit = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = o_done;
            1:       hit = (o_rws == RWS_READ);
            2:       hit = (o_rws != RWS_READ);
            default: hit = o_wdata_ready;
         endcase
         if (hit) at = cyc;
      end
      chk({tag, "_seen"}, 32'(hit), 32'd1);
   endtask

   // t0 is the cycle number of the first cycle after the handshake edge
   task automatic issue(input logic op, input logic burst, input logic [19:0] addr,
                        input logic [7:0] len, input logic [15:0] wd, input string tag,
                        output int t0);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_burst = burst;
      req_addr  = addr;
      req_len   = len;
      req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      t0 = cyc;
   endtask

   // PTS model for one read beat; returns the cycle of rdata_valid (or -1)
   task automatic pts_beat(input logic [15:0] w, input string tag, output int rv_at,
                           output logic [15:0] rd);
      int at;
      wait_for(1, 200, {tag, "_strobe"}, at);
      wait_for(2, 20, {tag, "_strobe_end"}, at);
      repeat (CAP_LAT - 1) @(negedge clk);
      for (int i = 15; i >= 0; i--) begin
         @(negedge clk);
         ser_in = w[i];
      end
      @(negedge clk);
      ser_in = 1'b0;
      rv_at  = o_rdata_valid ? cyc : -1;
      rd     = o_rdata;
   endtask

   initial begin
      int t0, d, rv0, rv1, rv2, wr_at;
      logic [15:0] rd0, rd1, rd2;

      // Reset
      repeat (3) @(negedge clk);
      chk("reset_outs", outs_now(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 32'({o_req_ready, o_busy}), 32'b10);

      // Single write 0x12345 / 0xBEEF
      issue(1'b0, 1'b0, 20'h12345, 8'h00, 16'hBEEF, "w1", t0);
      wait_for(0, 100, "w1_done", d);
      repeat (2) @(negedge clk);
      chk("w1_done_lat", 32'(d - t0), 32'd24);
      chk("w1_addr", ser_word(t0, 20, 1), 32'h12345);
      chk("w1_data", ser_word(t0, 20, 2), 32'h0BEEF);
      chk("w1_rws", rws_seq(t0 + 19, 6), 32'h01248);
      chk("w1_busy_ready", 32'({log_q[d-1].busy, log_q[d].busy, log_q[d+1].req_ready}),
          32'b101);
      chk("w1_single_mode", 32'({log_q[t0].mode_sel, log_q[t0+20].burst_en}), 32'd0);

      // Single read returning 0xA55A
      issue(1'b1, 1'b0, 20'h00ABC, 8'h00, 16'h0000, "r1", t0);
      pts_beat(16'hA55A, "r1", rv0, rd0);
      wait_for(0, 20, "r1_done", d);
      repeat (2) @(negedge clk);
      chk("r1_rv_lat", 32'(rv0 - t0), 32'd41);
      chk("r1_rdata", 32'(rd0), 32'hA55A);
      chk("r1_done_lat", 32'(d - t0), 32'd42);
      chk("r1_rv_count", 32'(count_fld(t0, d + 1, 0)), 32'd1);
      chk("r1_addr", ser_word(t0, 20, 1), 32'h00ABC);
      chk("r1_no_data", ser_word(t0, 20, 2), 32'h0);

      // Burst read, len 3
      issue(1'b1, 1'b1, 20'h00010, 8'd3, 16'h0000, "br", t0);
      pts_beat(16'h0001, "br0", rv0, rd0);
      pts_beat(16'h0002, "br1", rv1, rd1);
      pts_beat(16'h0003, "br2", rv2, rd2);
      wait_for(0, 20, "br_done", d);
      repeat (2) @(negedge clk);
      chk("br_len", ser_word(t0, 8, 0), 32'h03);
      chk("br_addr", ser_word(t0 + 8, 20, 1), 32'h00010);
      chk("br_rv_lat", 32'({8'(rv0 - t0), 8'(rv1 - t0), 8'(rv2 - t0)}), 32'h00_31_47_5D);
      chk("br_rdata", {rd0, rd1} , 32'h0001_0002);
      chk("br_rdata3", 32'(rd2), 32'h0003);
      chk("br_done_lat", 32'(d - t0), 32'd94);
      chk("br_rv_count", 32'(count_fld(t0, d + 1, 0)), 32'd3);
      chk("br_burst_en", 32'({log_q[t0+27].burst_en, log_q[t0+28].burst_en,
                              log_q[t0+93].burst_en, log_q[d].burst_en}), 32'b0110);
      chk("br_mode_sel", 32'(log_q[t0].mode_sel), 32'd1);

      // Burst write, len 2, second word held back for 10 cycles
      issue(1'b0, 1'b1, 20'h00200, 8'd2, 16'h5678, "bw", t0);
      wait_for(3, 100, "bw_wready", wr_at);
      chk("bw_wready_lat", 32'(wr_at - t0), 32'd32);
      repeat (10) @(negedge clk);
      wdata_valid = 1'b1;
      wdata       = 16'h1234;
      @(negedge clk);
      wdata_valid = 1'b0;
      wdata       = 16'h0000;
      wait_for(0, 100, "bw_done", d);
      repeat (2) @(negedge clk);
      chk("bw_len", ser_word(t0, 8, 0), 32'h02);
      chk("bw_word1", ser_word(t0 + 12, 16, 2), 32'h5678);
      chk("bw_stall_idle", 32'({ser_word(t0 + 32, 11, 2), rws_seq(t0 + 32, 4)}), 32'd0);
      chk("bw_word2", ser_word(t0 + 43, 16, 2), 32'h1234);
      chk("bw_wready_cnt", 32'(count_fld(t0, d, 2)), 32'd11);
      chk("bw_strobes", 32'(count_strobes(t0, d, RWS_WRITE)), 32'd2);
      chk("bw_done_lat", 32'(d - t0), 32'd63);

      // Burst write with len 0 behaves as one beat
      issue(1'b0, 1'b1, 20'h00001, 8'd0, 16'hFFFF, "l0", t0);
      wait_for(0, 100, "l0_done", d);
      repeat (2) @(negedge clk);
      chk("l0_done_lat", 32'(d - t0), 32'd32);
      chk("l0_len", ser_word(t0, 8, 0), 32'h00);
      chk("l0_beats", 32'({8'(count_strobes(t0, d, RWS_WRITE)), 8'(count_fld(t0, d, 2))}),
          32'h0100);

      // Burst write with len 1 for comparison
      issue(1'b0, 1'b1, 20'h00002, 8'd1, 16'h8001, "l1", t0);
      wait_for(0, 100, "l1_done", d);
      repeat (2) @(negedge clk);
      chk("l1_done_lat", 32'(d - t0), 32'd32);
      chk("l1_len", ser_word(t0, 8, 0), 32'h01);

      // Reset during CAPTURE of a single read
      issue(1'b1, 1'b0, 20'h00055, 8'h00, 16'h0000, "rs", t0);
      wait_for(1, 100, "rs_strobe", wr_at);
      wait_for(2, 20, "rs_strobe_end", wr_at);
      repeat (5) begin
         @(negedge clk);
         ser_in = 1'b1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      ser_in = 1'b0;
      chk("rs_outs", outs_now(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rs_ready_after", 32'({o_req_ready, o_busy}), 32'b10);
      repeat (40) @(negedge clk);
      chk("rs_no_rv_done", 32'({8'(count_fld(t0, cyc - 2, 0)), 8'(count_fld(t0, cyc - 2, 1))}),
          32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
